cc_decode_stage: RTL and testbench

//  - Classic-core decode stage. Accepts 32-bit instructions from fetch over valid/ready.
//  - Splits each instruction into opcode, register indices, the 25-bit immediate payload and the

---
 rtl/cc_pkg.sv | 62 ++++++
 rtl/cc_decode_stage_if.sv | 34 +++
 rtl/cc_skid_buf.sv | 67 ++++++
 rtl/cc_decode_stage.sv | 107 ++++++++++
 tb/tb_cc_decode_stage.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_pkg.sv
// Shared decode-stage types: opcodes, immediate-select codes and the decoded entry record.
// imm_gen uses the same imm_sel_e encoding.
package cc_pkg;

    // Width of the pc field carried inside dec_entry_t.
    localparam int unsigned PcW = 16;

    typedef enum logic [6:0] {
        OpNop  = 7'h00,
        OpLd   = 7'h01,
        OpSt   = 7'h02,
        OpBr   = 7'h03,
        OpLdi  = 7'h04,
        OpLdui = 7'h05,
        OpAdd  = 7'h06
    } opcode_e;

    typedef enum logic [2:0] {
        SelNone    = 3'd0,
        SelImmM    = 3'd1,
        SelImmBr   = 3'd2,
        SelImmLdi  = 3'd3,
        SelImmLdui = 3'd4
    } imm_sel_e;

    typedef struct packed {
        logic [PcW-1:0] pc;
        logic [6:0]     opcode;
        logic [24:0]    imm_src;
        imm_sel_e       imm_sel;
        logic [4:0]     rd;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic           rd_we;
        logic           illegal;
    } dec_entry_t;

    typedef struct packed {
        imm_sel_e imm_sel;
        logic     rd_we;
        logic     illegal;
    } op_ctrl_t;

    function automatic op_ctrl_t decode_op(logic [6:0] op);
        op_ctrl_t c;
        c.imm_sel = SelNone;
        c.rd_we   = 1'b0;
        c.illegal = 1'b0;
        case (op)
            OpNop:  ;
            OpLd:   begin c.imm_sel = SelImmM;    c.rd_we = 1'b1; end
            OpSt:   c.imm_sel = SelImmM;
            OpBr:   c.imm_sel = SelImmBr;
            OpLdi:  begin c.imm_sel = SelImmLdi;  c.rd_we = 1'b1; end
            OpLdui: begin c.imm_sel = SelImmLdui; c.rd_we = 1'b1; end
            OpAdd:  c.rd_we = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cc_decode_stage_if.sv
// Fetch-side and decode-output handshake bundle of the decode stage.
// master: the surrounding pipeline; slave: the decode stage itself.
interface cc_decode_stage_if #(
    parameter int unsigned PC_W = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [24:0]     out_imm_src;
    logic [2:0]      out_imm_sel;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic            out_rd_we;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_imm_src, out_imm_sel,
               out_rd, out_rs1, out_rs2, out_rd_we, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_imm_src, out_imm_sel,
               out_rd, out_rs1, out_rs2, out_rd_we, out_illegal
    );
endinterface

// File: rtl/cc_skid_buf.sv
// Two-entry skid buffer (main + skid) with registered ready and synchronous flush.
// Ready depends only on skid occupancy and flush, never on out_ready.
module cc_skid_buf #(
    parameter type payload_t = logic [7:0]
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  payload_t in_data,
    output logic     in_fire,
    output logic     out_valid,
    input  logic     out_ready,
    output payload_t out_data,
    output logic     out_fire
);
    payload_t main_q, main_d, skid_q, skid_d;
    logic     main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;

    assign in_ready  = !skid_valid_q && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;
    // A flush overrides a simultaneous output transfer.
    assign out_fire  = main_valid_q && out_ready && !flush;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_d       = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/cc_decode_stage.sv
// Classic-core decode stage: combinational field split and opcode decode ahead of a skid buffer.
// Optional performance counters are built only when CC_DEC_PERF_CNT_EN is defined.
module cc_decode_stage
    import cc_pkg::*;
#(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    cc_decode_stage_if.slave   bus,
    output logic               err_illegal,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   perf_instr_cnt,
    output logic [CNT_W-1:0]   perf_stall_cnt
);
    op_ctrl_t   ctrl;
    dec_entry_t dec_entry;
    dec_entry_t held;
    logic       in_fire;
    logic       out_fire;
    logic       out_valid;
    logic       err_q;

    always_comb begin
        ctrl              = decode_op(bus.in_instr[31:25]);
        dec_entry         = '0;
        dec_entry.pc      = PcW'(bus.in_pc);
        dec_entry.opcode  = bus.in_instr[31:25];
        dec_entry.imm_src = bus.in_instr[24:0];
        dec_entry.imm_sel = ctrl.imm_sel;
        dec_entry.rd      = bus.in_instr[24:20];
        dec_entry.rs1     = bus.in_instr[19:15];
        dec_entry.rs2     = bus.in_instr[14:10];
        dec_entry.rd_we   = ctrl.rd_we;
        dec_entry.illegal = ctrl.illegal;
    end

    cc_skid_buf #(
        .payload_t (dec_entry_t)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (dec_entry),
        .in_fire   (in_fire),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (held),
        .out_fire  (out_fire)
    );

    assign bus.out_valid   = out_valid;
    assign bus.out_pc      = PC_W'(held.pc);
    assign bus.out_opcode  = held.opcode;
    assign bus.out_imm_src = held.imm_src;
    assign bus.out_imm_sel = held.imm_sel;
    assign bus.out_rd      = held.rd;
    assign bus.out_rs1     = held.rs1;
    assign bus.out_rs2     = held.rs2;
    assign bus.out_rd_we   = held.rd_we;
    assign bus.out_illegal = held.illegal;

    // Setting wins over a simultaneous clear; flush leaves the flag alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (in_fire && dec_entry.illegal) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err_illegal = err_q;

`ifdef CC_DEC_PERF_CNT_EN
    logic [CNT_W-1:0] instr_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_fire && !(&instr_cnt_q)) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
            if (out_valid && !bus.out_ready && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign perf_instr_cnt = instr_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    logic perf_unused;
    assign perf_unused    = out_fire;
    assign perf_instr_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cc_decode_stage.sv
// Bench for cc_decode_stage: a queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic. Honours CC_DEC_PERF_CNT_EN.
module tb_cc_decode_stage;
    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             err_clr = 1'b0;
    logic             err_illegal;
    logic [CNT_W-1:0] perf_instr_cnt;
    logic [CNT_W-1:0] perf_stall_cnt;

    cc_decode_stage_if #(.PC_W(PC_W)) bus ();

    cc_decode_stage #(
        .PC_W  (PC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .bus            (bus),
        .err_illegal    (err_illegal),
        .err_clr        (err_clr),
        .perf_instr_cnt (perf_instr_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
    } txn_t;

    txn_t   mq[$];
    logic   m_err = 1'b0;
    longint m_icnt = 0;
    longint m_scnt = 0;
    bit     chk_en = 1'b0;

    function automatic void chk(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Decode table straight from the opcode list.
    function automatic void ref_ctrl(input logic [6:0] op, output logic [2:0] sel,
                                     output logic we, output logic ill);
        ill = 1'b0;
        case (op)
            7'h00:   begin sel = 3'd0; we = 1'b0; end
            7'h01:   begin sel = 3'd1; we = 1'b1; end
            7'h02:   begin sel = 3'd1; we = 1'b0; end
            7'h03:   begin sel = 3'd2; we = 1'b0; end
            7'h04:   begin sel = 3'd3; we = 1'b1; end
            7'h05:   begin sel = 3'd4; we = 1'b1; end
            7'h06:   begin sel = 3'd0; we = 1'b1; end
            default: begin sel = 3'd0; we = 1'b0; ill = 1'b1; end
        endcase
    endfunction

    // Reference model: the stage is a 2-deep FIFO that refuses input when full or flushing.
    always @(posedge clk) begin
        int       sz;
        bit       ifire;
        logic [2:0] sel;
        logic     we, ill;
        if (!rst_n) begin
            mq.delete();
            m_err  = 1'b0;
            m_icnt = 0;
            m_scnt = 0;
        end else begin
            sz    = mq.size();
            ifire = bus.in_valid && (sz < 2) && !flush;
            ref_ctrl(bus.in_instr[31:25], sel, we, ill);
            if (sz > 0 && !bus.out_ready) m_scnt++;
            if (flush) begin
                mq.delete();
            end else begin
                if (sz > 0 && bus.out_ready) begin
                    void'(mq.pop_front());
                    m_icnt++;
                end
                if (ifire) mq.push_back('{pc: bus.in_pc, instr: bus.in_instr});
            end
            if (ifire && ill) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        txn_t       t;
        logic [2:0] sel;
        logic       we, ill;
        if (chk_en) begin
            chk("in_ready", bus.in_ready, (mq.size() < 2) && !flush);
            chk("out_valid", bus.out_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                t = mq[0];
                ref_ctrl(t.instr[31:25], sel, we, ill);
                chk("out_pc", bus.out_pc, t.pc);
                chk("out_opcode", bus.out_opcode, t.instr[31:25]);
                chk("out_imm_src", bus.out_imm_src, t.instr[24:0]);
                chk("out_imm_sel", bus.out_imm_sel, sel);
                chk("out_rd", bus.out_rd, t.instr[24:20]);
                chk("out_rs1", bus.out_rs1, t.instr[19:15]);
                chk("out_rs2", bus.out_rs2, t.instr[14:10]);
                chk("out_rd_we", bus.out_rd_we, we);
                chk("out_illegal", bus.out_illegal, ill);
            end
            chk("err_illegal", err_illegal, m_err);
`ifdef CC_DEC_PERF_CNT_EN
            chk("perf_instr_cnt", perf_instr_cnt, CNT_W'(m_icnt));
            chk("perf_stall_cnt", perf_stall_cnt, CNT_W'(m_scnt));
`else
            chk("perf_instr_cnt", perf_instr_cnt, 0);
            chk("perf_stall_cnt", perf_stall_cnt, 0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [PC_W-1:0] pc,
                         input logic rdy);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        r  = $urandom();
        op = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 6)) : 7'($urandom());
        return {op, r[24:0]};
    endfunction

    int acc;

    initial begin
        drive(1'b0, 32'h0, '0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        at_neg();
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_opcode", bus.out_opcode, 7'h0);
        chk("reset_err", err_illegal, 1'b0);

        // 1: streaming LDI, LD, BR at full rate
        step();
        drive(1'b1, 32'h0880_0123, 16'h0000, 1'b1);
        step();
        at_neg();
        chk("t1_valid", bus.out_valid, 1'b1);
        chk("t1_ldi_sel", bus.out_imm_sel, 3'd3);
        chk("t1_ldi_rd", bus.out_rd, 5'd8);
        chk("t1_ldi_imm", bus.out_imm_src, 25'h080_0123);
        chk("t1_ldi_we", bus.out_rd_we, 1'b1);
        drive(1'b1, {7'h01, 25'h0123456}, 16'h0004, 1'b1);
        step();
        drive(1'b1, {7'h03, 25'h1000001}, 16'h0008, 1'b1);
        step();
        at_neg();
        chk("t1_br_opcode", bus.out_opcode, 7'h03);
        chk("t1_br_sel", bus.out_imm_sel, 3'd2);
        chk("t1_br_pc", bus.out_pc, 16'h0008);
        drive(1'b0, 32'h0, '0, 1'b1);
        step();

        // 2: stall for three cycles with input pending
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {7'h06, 25'(i * 3 + 1)}, PC_W'(16'h0010 + 4 * acc), 1'b0);
            if (bus.in_ready) acc++;
            step();
            at_neg();
            chk("t2_hold_pc", bus.out_pc, 16'h0010);
        end
        chk("t2_accepted", acc, 2);
        chk("t2_model_depth", mq.size(), 2);
        chk("t2_in_ready", bus.in_ready, 1'b0);
        drive(1'b0, 32'h0, '0, 1'b1);
        step();
        at_neg();
        chk("t2_second_pc", bus.out_pc, 16'h0014);
        step();
        at_neg();
        chk("t2_drained", bus.out_valid, 1'b0);

        // 3: illegal opcode and sticky error flag
        drive(1'b1, {7'h7F, 25'h1AB_CDEF}, 16'h0020, 1'b1);
        step();
        at_neg();
        chk("t3_illegal", bus.out_illegal, 1'b1);
        chk("t3_sel", bus.out_imm_sel, 3'd0);
        chk("t3_we", bus.out_rd_we, 1'b0);
        chk("t3_err", err_illegal, 1'b1);
        drive(1'b1, {7'h40, 25'h0000055}, 16'h0024, 1'b1);
        err_clr = 1'b1;
        step();
        at_neg();
        chk("t3_err_set_wins", err_illegal, 1'b1);
        drive(1'b0, 32'h0, '0, 1'b1);
        step();
        at_neg();
        chk("t3_err_cleared", err_illegal, 1'b0);
        err_clr = 1'b0;
        step();

        // 4: flush with both entries full
        drive(1'b1, {7'h01, 25'h0000111}, 16'h0030, 1'b0);
        step();
        drive(1'b1, {7'h01, 25'h0000222}, 16'h0034, 1'b0);
        step();
        drive(1'b1, {7'h02, 25'h0000333}, 16'h0038, 1'b1);
        flush = 1'b1;
        at_neg();
        chk("t4_in_ready_flush", bus.in_ready, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b1, {7'h05, 25'h1FF_FFFF}, 16'h0040, 1'b1);
        at_neg();
        chk("t4_flushed", bus.out_valid, 1'b0);
        step();
        at_neg();
        chk("t4_after_sel", bus.out_imm_sel, 3'd4);
        chk("t4_after_pc", bus.out_pc, 16'h0040);
        drive(1'b0, 32'h0, '0, 1'b1);
        step();

        // 5: reset while stalled
        drive(1'b1, {7'h04, 25'h0A5_A5A5}, 16'h0050, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        at_neg();
        chk("t5_valid", bus.out_valid, 1'b0);
        chk("t5_pc", bus.out_pc, 16'h0);
        chk("t5_imm", bus.out_imm_src, 25'h0);
        chk("t5_rd", bus.out_rd, 5'h0);
        drive(1'b0, 32'h0, '0, 1'b1);
        rst_n = 1'b1;
        step();
        at_neg();
        chk("t5_in_ready", bus.in_ready, 1'b1);

        // 6: 10 transfers then 4 stalled cycles
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, {7'h06, 25'($urandom())}, PC_W'(4 * i), 1'b1);
            step();
        end
        drive(1'b0, 32'h0, '0, 1'b1);
        step();
        drive(1'b1, {7'h00, 25'h0}, 16'h0100, 1'b0);
        step();
        drive(1'b0, 32'h0, '0, 1'b0);
        repeat (4) step();
        at_neg();
`ifdef CC_DEC_PERF_CNT_EN
        chk("t6_instr_cnt", perf_instr_cnt, 10);
        chk("t6_stall_cnt", perf_stall_cnt, 4);
`else
        chk("t6_instr_cnt", perf_instr_cnt, 0);
        chk("t6_stall_cnt", perf_stall_cnt, 0);
`endif
        drive(1'b0, 32'h0, '0, 1'b1);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, rand_instr(), PC_W'($urandom()),
                  $urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 39) == 0);
            err_clr = ($urandom_range(0, 19) == 0);
            rst_n   = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n = 1'b1;
        flush = 1'b0;
        err_clr = 1'b0;
        drive(1'b0, 32'h0, '0, 1'b1);
        step();
        at_neg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
